// File: rtl/mux_nto1_stream_if.sv
// Stream mux bus: N input channels with valid/ready,
// one registered output channel with valid/ready and source tag.
interface mux_nto1_stream_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
);
    logic [N*WIDTH-1:0] A;
    logic [N-1:0]       A_valid;
    logic [N-1:0]       A_ready;
    logic [SEL_W-1:0]   S;
    logic               mode;
    logic [WIDTH-1:0]   Z;
    logic               Z_valid;
    logic               Z_ready;
    logic [SEL_W-1:0]   Z_src;

    modport slave (
        input  A, A_valid, S, mode, Z_ready,
        output A_ready, Z, Z_valid, Z_src
    );

    modport master (
        output A, A_valid, S, mode, Z_ready,
        input  A_ready, Z, Z_valid, Z_src
    );
endinterface

// File: rtl/mux_nto1_stream.sv
// N-to-1 stream mux into a single output register.
// Fixed select (mode 0) or round-robin over valid channels (mode 1).
module mux_nto1_stream #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input logic              clk,
    input logic              rst,
    mux_nto1_stream_if.slave bus
);
    localparam int M = 2 ** SEL_W;
    localparam logic [SEL_W:0] NN    = (SEL_W + 1)'(N);
    localparam logic [SEL_W:0] NLAST = (SEL_W + 1)'(N - 1);

    logic [WIDTH-1:0]          z_q;
    logic                      z_valid_q;
    logic [SEL_W-1:0]          z_src_q;
    logic [SEL_W-1:0]          ptr_q;
    logic [SEL_W-1:0]          ptr_d;

    logic [M-1:0]              valid_pad;
    logic [M-1:0]              ready_pad;
    logic [M-1:0][WIDTH-1:0]   data_pad;
    logic                      load_ok;
    logic                      gnt;
    logic [SEL_W-1:0]          gnt_idx;
    logic [SEL_W:0]            idx;

    // Pad channels out to 2^SEL_W so select-width indexing is always legal.
    always_comb begin
        valid_pad = '0;
        data_pad  = '0;
        for (int i = 0; i < N; i++) begin
            valid_pad[i] = bus.A_valid[i];
            data_pad[i]  = bus.A[i*WIDTH +: WIDTH];
        end
    end

    // Grant decision: fixed select or first valid channel from ptr.
    always_comb begin
        load_ok = !z_valid_q || bus.Z_ready;
        gnt     = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        if (!bus.mode) begin
            if (({1'b0, bus.S} < NN) && valid_pad[bus.S]) begin
                gnt     = 1'b1;
                gnt_idx = bus.S;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = {1'b0, ptr_q} + (SEL_W + 1)'(k);
                if (idx >= NN) begin
                    idx = idx - NN;
                end
                if (!gnt && valid_pad[idx[SEL_W-1:0]]) begin
                    gnt     = 1'b1;
                    gnt_idx = idx[SEL_W-1:0];
                end
            end
        end
        gnt       = gnt && load_ok;
        ready_pad = '0;
        if (gnt) begin
            ready_pad[gnt_idx] = 1'b1;
        end
        ptr_d = ({1'b0, gnt_idx} == NLAST) ? '0 : gnt_idx + SEL_W'(1);
    end

    assign bus.A_ready = ready_pad[N-1:0];
    assign bus.Z       = z_q;
    assign bus.Z_valid = z_valid_q;
    assign bus.Z_src   = z_src_q;

    // Output register: load on grant, drop valid on drain, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q       <= '0;
            z_valid_q <= 1'b0;
            z_src_q   <= '0;
            ptr_q     <= '0;
        end else if (gnt) begin
            z_q       <= data_pad[gnt_idx];
            z_src_q   <= gnt_idx;
            z_valid_q <= 1'b1;
            if (bus.mode) begin
                ptr_q <= ptr_d;
            end
        end else if (z_valid_q && bus.Z_ready) begin
            z_valid_q <= 1'b0;
        end
    end
endmodule
